// File: rtl/bfp_norm_ctrl_pkg.sv
// Shared types and width helpers for the block-floating-point normalizer.
package bfp_norm_ctrl_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // ceil(log2(n)), never below 1 so every derived vector has at least one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int enc_width(input int data_w);
        return clog2_min1(data_w);
    endfunction

    function automatic int cnt_width(input int blk_len);
        return clog2_min1(blk_len);
    endfunction

endpackage

// File: rtl/bfp_norm_ctrl_lsd.sv
// Leading-sign detector: counts the redundant sign bits of a two's-complement word.
// All-zero and all-one words report a_width-1.
module DW_lsd
    import bfp_norm_ctrl_pkg::*;
#(
    parameter int a_width = 16
) (
    input  logic [a_width-1:0]            a,
    output logic [enc_width(a_width)-1:0] enc
);

    localparam int ENC_W = enc_width(a_width);

    logic [ENC_W-1:0] cnt_v;
    logic             run_v;

    // Walk down from the bit below the MSB until the first bit that differs from the sign.
    always_comb begin
        cnt_v = '0;
        run_v = 1'b1;
        for (int i = a_width - 2; i >= 0; i--) begin
            if (run_v && (a[i] == a[a_width-1])) begin
                cnt_v = cnt_v + ENC_W'(1);
            end else begin
                run_v = 1'b0;
            end
        end
        enc = cnt_v;
    end

endmodule

// File: rtl/bfp_norm_ctrl.sv
// Block-floating-point normalizer: collects BLK_LEN samples, finds the smallest
// redundant-sign-bit count in the block, then replays every sample shifted left
// by that common amount together with the shift as the block exponent.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FILL  | accepting samples into the buffer, tracking the block minimum
//   DRAIN | presenting normalized samples until the last one is taken
module bfp_norm_ctrl
    import bfp_norm_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BLK_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [enc_width(DATA_W)-1:0]  out_exp,
    output logic                          out_last
);

    localparam int ENC_W = enc_width(DATA_W);
    localparam int CNT_W = cnt_width(BLK_LEN);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ENC_W-1:0]   min_enc_q, min_enc_d;
    logic [DATA_W-1:0]  mem_q [BLK_LEN];

    logic [ENC_W-1:0]   enc;
    logic               accept;
    logic               xfer;
    logic               last_wr;
    logic               last_rd;
    logic [DATA_W-1:0]  data_shift;

    DW_lsd #(
        .a_width (DATA_W)
    ) u_lsd (
        .a   (in_data),
        .enc (enc)
    );

    // Shifting by the block minimum can never push a significant bit past the sign.
    assign data_shift = mem_q[rd_cnt_q] << min_enc_q;

    // Next-state, counter updates and handshake/output decode.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        min_enc_d = min_enc_q;

        in_ready  = (state_q == FILL);
        out_valid = (state_q == DRAIN);
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        last_wr   = (wr_cnt_q == CNT_W'(BLK_LEN - 1));
        last_rd   = (rd_cnt_q == CNT_W'(BLK_LEN - 1));

        out_data  = out_valid ? data_shift : '0;
        out_exp   = out_valid ? min_enc_q : '0;
        out_last  = out_valid && last_rd;

        if (clear) begin
            state_d   = FILL;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            min_enc_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if ((wr_cnt_q == '0) || (enc < min_enc_q)) begin
                            min_enc_d = enc;
                        end
                        if (last_wr) begin
                            wr_cnt_d = '0;
                            state_d  = DRAIN;
                        end else begin
                            wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (last_rd) begin
                            rd_cnt_d = '0;
                            state_d  = FILL;
                        end else begin
                            rd_cnt_d = rd_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            min_enc_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            min_enc_q <= min_enc_d;
        end
    end

    // Sample buffer; stale contents are harmless since every slot is rewritten before a drain.
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            mem_q[wr_cnt_q] <= in_data;
        end
    end

endmodule
